// File: rtl/cache_access_ctrl_if.sv
// CPU-side request/response bundle for cache_access_ctrl.
//   req_valid  : CPU has a request on req_addr
//   req_ready  : controller can accept a request (idle)
//   req_addr   : byte address of the access
//   resp_valid : one-cycle completion pulse
//   resp_hit   : qualifies resp_valid, 1 when the access hit
interface cache_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_hit;

  modport master (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_hit
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_hit
  );
endinterface

// File: rtl/cache_access_ctrl.sv
// Cache access controller: sequences lookup, line refill and victim
// replacement for one CPU access at a time, keeps per-set LRU ages and
// hit/miss/replace statistics.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cpu                   CPU request/response handshake (slave side)
//   tag/index/block_offset latched address fields driven to the cache
//   find_start/update_start one-cycle lookup / fill commands
//   found_in_cache, done  lookup result (done is a pulse)
//   way_index             cache way pointer, accessed way = way_index-1
//   replace, updated      cache reports full set / fill complete
//   block_replace, replace_way  forced write of the LRU victim
//   block                 refill line driven to the cache
//   mem_req/mem_addr, mem_valid/mem_block  line fetch from memory
//   hit_count/miss_count/replace_count  wrapping statistics
//
// state     | meaning
// ----------+---------------------------------------------------
// IDLE      | ready for a request, latch address on handshake
// FIND      | find_start pulse to the cache
// WAIT_FIND | wait for lookup done; hit -> RESP, miss -> MEM
// MEM       | mem_req held until the line returns
// FILL      | update_start pulse to the cache
// WAIT_FILL | wait for updated (free way) or replace (set full)
// REPLACE   | block_replace with LRU victim until updated
// RESP      | resp_valid pulse, back to IDLE
module cache_access_ctrl #(
  parameter int WAY             = 4,
  parameter int BLOCK_SIZE_BYTE = 16,
  parameter int CACHE_SIZE_BYTE = 32768,
  localparam int SET       = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY),
  localparam int SET_INDEX = $clog2(SET),
  localparam int OFFSET    = $clog2(BLOCK_SIZE_BYTE),
  localparam int TAG_W     = 32 - SET_INDEX - OFFSET,
  localparam int AGE_W     = $clog2(WAY)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  cache_access_ctrl_if.slave           cpu,
  output logic [TAG_W-1:0]             tag,
  output logic [SET_INDEX-1:0]         index,
  output logic [OFFSET-1:0]            block_offset,
  output logic                         find_start,
  output logic                         update_start,
  input  logic                         found_in_cache,
  input  logic                         done,
  input  logic [4:0]                   way_index,
  input  logic                         replace,
  input  logic                         updated,
  output logic                         block_replace,
  output logic [4:0]                   replace_way,
  output logic [BLOCK_SIZE_BYTE*8-1:0] block,
  output logic                         mem_req,
  output logic [31:0]                  mem_addr,
  input  logic                         mem_valid,
  input  logic [BLOCK_SIZE_BYTE*8-1:0] mem_block,
  output logic [15:0]                  hit_count,
  output logic [15:0]                  miss_count,
  output logic [15:0]                  replace_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FIND, S_WAIT_FIND, S_MEM, S_FILL, S_WAIT_FILL, S_REPLACE, S_RESP
  } state_t;

  state_t state;

  logic [WAY-1:0][AGE_W-1:0] age [SET];

  logic [4:0]                way_dec;
  logic [AGE_W-1:0]          acc_way;
  logic [WAY-1:0][AGE_W-1:0] set_age;
  logic [WAY-1:0][AGE_W-1:0] set_age_next;
  logic [AGE_W-1:0]          victim;
  logic                      unused_way_bits;

  // The cache reports a pointer one past the way it touched.
  assign way_dec         = way_index - 5'd1;
  assign unused_way_bits = ^way_dec[4:AGE_W];

  // In REPLACE the touched way is our own victim, otherwise the cache's.
  assign acc_way = (state == S_REPLACE) ? replace_way[AGE_W-1:0]
                                        : way_dec[AGE_W-1:0];

  // Ages form a recency ranking: the touched way becomes 0 and every way
  // younger than it ages by one, so the set stays a permutation.
  always_comb begin
    set_age      = age[index];
    set_age_next = set_age;
    victim       = '0;
    for (int w = 0; w < WAY; w++) begin
      if (w == int'(acc_way))
        set_age_next[w] = '0;
      else if (set_age[w] < set_age[acc_way])
        set_age_next[w] = set_age[w] + 1'b1;
      if (set_age[w] == AGE_W'(WAY - 1))
        victim = AGE_W'(w);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cpu.req_ready  <= 1'b1;
      cpu.resp_valid <= 1'b0;
      cpu.resp_hit   <= 1'b0;
      find_start     <= 1'b0;
      update_start   <= 1'b0;
      block_replace  <= 1'b0;
      replace_way    <= '0;
      mem_req        <= 1'b0;
      mem_addr       <= '0;
      tag            <= '0;
      index          <= '0;
      block_offset   <= '0;
      block          <= '0;
      hit_count      <= '0;
      miss_count     <= '0;
      replace_count  <= '0;
      for (int s = 0; s < SET; s++)
        for (int w = 0; w < WAY; w++)
          age[s][w] <= AGE_W'(w);
    end else begin
      find_start     <= 1'b0;
      update_start   <= 1'b0;
      cpu.resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cpu.req_valid) begin
            tag           <= cpu.req_addr[31:SET_INDEX+OFFSET];
            index         <= cpu.req_addr[SET_INDEX+OFFSET-1:OFFSET];
            block_offset  <= cpu.req_addr[OFFSET-1:0];
            mem_addr      <= {cpu.req_addr[31:OFFSET], {OFFSET{1'b0}}};
            cpu.req_ready <= 1'b0;
            find_start    <= 1'b1;
            state         <= S_FIND;
          end
        end
        S_FIND: state <= S_WAIT_FIND;
        S_WAIT_FIND: begin
          if (done) begin
            if (found_in_cache) begin
              age[index]     <= set_age_next;
              hit_count      <= hit_count + 16'd1;
              cpu.resp_valid <= 1'b1;
              cpu.resp_hit   <= 1'b1;
              state          <= S_RESP;
            end else begin
              miss_count <= miss_count + 16'd1;
              mem_req    <= 1'b1;
              state      <= S_MEM;
            end
          end
        end
        S_MEM: begin
          if (mem_valid) begin
            block        <= mem_block;
            mem_req      <= 1'b0;
            update_start <= 1'b1;
            state        <= S_FILL;
          end
        end
        S_FILL: state <= S_WAIT_FILL;
        S_WAIT_FILL: begin
          if (replace) begin
            replace_way   <= 5'(victim);
            block_replace <= 1'b1;
            state         <= S_REPLACE;
          end else if (updated) begin
            age[index]     <= set_age_next;
            cpu.resp_valid <= 1'b1;
            cpu.resp_hit   <= 1'b0;
            state          <= S_RESP;
          end
        end
        S_REPLACE: begin
          if (updated) begin
            block_replace  <= 1'b0;
            age[index]     <= set_age_next;
            replace_count  <= replace_count + 16'd1;
            cpu.resp_valid <= 1'b1;
            cpu.resp_hit   <= 1'b0;
            state          <= S_RESP;
          end
        end
        S_RESP: begin
          cpu.req_ready <= 1'b1;
          cpu.resp_hit  <= 1'b0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_access_ctrl.sv
// Bench for cache_access_ctrl with default parameters (4 ways, 512 sets,
// 16-byte lines). The bench plays the cache and memory; the reference keeps
// each set as a recency list (most recent first, victim last).
module tb_cache_access_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  cache_access_ctrl_if bus();
  logic [18:0]  tag;
  logic [8:0]   index;
  logic [3:0]   block_offset;
  logic         find_start, update_start, found_in_cache, done;
  logic [4:0]   way_index;
  logic         replace, updated, block_replace;
  logic [4:0]   replace_way;
  logic [127:0] block, mem_block;
  logic         mem_req, mem_valid;
  logic [31:0]  mem_addr;
  logic [15:0]  hit_count, miss_count, replace_count;

  cache_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cpu(bus),
    .tag(tag), .index(index), .block_offset(block_offset),
    .find_start(find_start), .update_start(update_start),
    .found_in_cache(found_in_cache), .done(done), .way_index(way_index),
    .replace(replace), .updated(updated),
    .block_replace(block_replace), .replace_way(replace_way), .block(block),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_block(mem_block),
    .hit_count(hit_count), .miss_count(miss_count), .replace_count(replace_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fs_pulses = 0;
  int resp_pulses = 0;

  // Sampled before the edge's register updates land.
  always @(posedge clk) begin
    if (find_start) fs_pulses++;
    if (bus.resp_valid) resp_pulses++;
  end

  // Reference: cache contents, recency lists, expected statistics.
  bit          vld  [512][4];
  logic [18:0] ctag [512][4];
  int          rec  [512][$];
  int          m_hits, m_misses, m_repls;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 512; s++) begin
      rec[s].delete();
      for (int w = 0; w < 4; w++) begin
        rec[s].push_back(w);
        vld[s][w] = 1'b0;
        ctag[s][w] = '0;
      end
    end
    m_hits = 0; m_misses = 0; m_repls = 0;
  endtask

  task automatic touch(input int idx, input int w);
    int pos = 0;
    for (int i = 0; i < rec[idx].size(); i++) if (rec[idx][i] == w) pos = i;
    rec[idx].delete(pos);
    rec[idx].push_front(w);
  endtask

  task automatic do_access(input logic [31:0] addr, input bit hold,
                           output bit got_hit, output bit got_repl, output logic [4:0] got_rway);
    int idx, n, d, fw, vic, hw, fs0;
    logic [18:0]  tg;
    logic [127:0] data;
    bit hit;
    idx = int'(addr[12:4]);
    tg  = addr[31:13];
    hit = 0; hw = 0; fw = -1;
    for (int w = 0; w < 4; w++) if (vld[idx][w] && ctag[idx][w] == tg) begin hit = 1; hw = w; end
    for (int w = 3; w >= 0; w--) if (!vld[idx][w]) fw = w;
    data = {$urandom, $urandom, $urandom, $urandom};
    got_hit = 0; got_repl = 0; got_rway = '0;
    fs0 = fs_pulses;

    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready before request", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    if (hold) bus.req_addr = ~addr;
    else bus.req_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!find_start && n < 10) begin @(negedge clk); n++; end
    chk("find_start", find_start, 1'b1);
    chk("latched fields", {tag, index, block_offset}, {addr[31:13], addr[12:4], addr[3:0]});
    chk("req_ready busy", bus.req_ready, 1'b0);
    @(negedge clk);
    chk("find_start one cycle", find_start, 1'b0);
    d = int'($urandom_range(0, 2));
    for (int i = 0; i < d; i++) begin
      mem_valid = 1'b1; mem_block = ~data;
      @(negedge clk);
      mem_valid = 1'b0;
    end
    done = 1'b1; found_in_cache = hit; way_index = 5'(hw + 1);
    @(negedge clk);
    done = 1'b0; found_in_cache = 1'b0;

    if (hit) begin
      m_hits++;
      touch(idx, hw);
    end else begin
      m_misses++;
      n = 0;
      while (!mem_req && n < 10) begin @(negedge clk); n++; end
      chk("mem_req", mem_req, 1'b1);
      chk("mem_addr", mem_addr, {addr[31:4], 4'h0});
      d = int'($urandom_range(0, 2));
      for (int i = 0; i < d; i++) begin
        done = 1'b1; found_in_cache = 1'b1;
        @(negedge clk);
        done = 1'b0; found_in_cache = 1'b0;
      end
      mem_valid = 1'b1; mem_block = data;
      @(negedge clk);
      mem_valid = 1'b0; mem_block = ~data;
      n = 0;
      while (!update_start && n < 10) begin @(negedge clk); n++; end
      chk("update_start", update_start, 1'b1);
      chk("mem_req dropped", mem_req, 1'b0);
      chk("block latched", block, data);
      @(negedge clk);
      chk("update_start one cycle", update_start, 1'b0);
      d = int'($urandom_range(0, 2));
      for (int i = 0; i < d; i++) @(negedge clk);
      if (fw >= 0) begin
        way_index = 5'(fw + 1); updated = 1'b1;
        @(negedge clk);
        updated = 1'b0;
        vld[idx][fw] = 1'b1; ctag[idx][fw] = tg;
        touch(idx, fw);
      end else begin
        vic = rec[idx][rec[idx].size() - 1];
        replace = 1'b1;
        @(negedge clk);
        replace = 1'b0;
        n = 0;
        while (!block_replace && n < 10) begin @(negedge clk); n++; end
        chk("block_replace", block_replace, 1'b1);
        got_repl = block_replace;
        got_rway = replace_way;
        chk("replace_way", replace_way, 5'(vic));
        d = int'($urandom_range(0, 2));
        for (int i = 0; i < d; i++) @(negedge clk);
        chk("block stable", block, data);
        updated = 1'b1;
        @(negedge clk);
        updated = 1'b0;
        ctag[idx][vic] = tg;
        touch(idx, vic);
        m_repls++;
      end
    end

    n = 0;
    while (!bus.resp_valid && n < 10) begin @(negedge clk); n++; end
    chk("resp_valid", bus.resp_valid, 1'b1);
    chk("resp_hit", bus.resp_hit, hit);
    chk("block_replace low", block_replace, 1'b0);
    got_hit = bus.resp_hit;
    chk("hit_count", hit_count, 16'(m_hits));
    chk("miss_count", miss_count, 16'(m_misses));
    chk("replace_count", replace_count, 16'(m_repls));
    chk("single acceptance", 32'(fs_pulses - fs0), 32'd1);
    bus.req_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          hold;
    bit          hit;
    bit          repl;
    logic [4:0]  rway;
    int          hits;
    int          misses;
    int          repls;
  } vec_t;

  vec_t vecs [16];

  initial begin
    bit g_hit, g_repl;
    logic [4:0] g_rway;
    int n, rs0;

    vecs[0]  = '{32'h0000_1230, 1'b0, 1'b0, 1'b0, 5'd0, 0, 1, 0};
    vecs[1]  = '{32'h0000_1230, 1'b0, 1'b1, 1'b0, 5'd0, 1, 1, 0};
    vecs[2]  = '{32'h0000_123C, 1'b0, 1'b1, 1'b0, 5'd0, 2, 1, 0};
    vecs[3]  = '{32'h0000_2230, 1'b1, 1'b0, 1'b0, 5'd0, 2, 2, 0};
    vecs[4]  = '{32'h0000_4230, 1'b0, 1'b0, 1'b0, 5'd0, 2, 3, 0};
    vecs[5]  = '{32'h0000_6230, 1'b0, 1'b0, 1'b0, 5'd0, 2, 4, 0};
    vecs[6]  = '{32'h0000_8230, 1'b0, 1'b0, 1'b0, 5'd0, 2, 5, 0};
    vecs[7]  = '{32'h0000_A230, 1'b0, 1'b0, 1'b1, 5'd0, 2, 6, 1};
    vecs[8]  = '{32'h0000_A230, 1'b0, 1'b1, 1'b0, 5'd0, 3, 6, 1};
    vecs[9]  = '{32'h0000_2230, 1'b0, 1'b0, 1'b1, 5'd1, 3, 7, 2};
    vecs[10] = '{32'h0000_2450, 1'b0, 1'b0, 1'b0, 5'd0, 3, 8, 2};
    vecs[11] = '{32'h0000_4450, 1'b0, 1'b0, 1'b0, 5'd0, 3, 9, 2};
    vecs[12] = '{32'h0000_6450, 1'b0, 1'b0, 1'b0, 5'd0, 3, 10, 2};
    vecs[13] = '{32'h0000_8450, 1'b0, 1'b0, 1'b0, 5'd0, 3, 11, 2};
    vecs[14] = '{32'h0000_2450, 1'b0, 1'b1, 1'b0, 5'd0, 4, 11, 2};
    vecs[15] = '{32'h0000_A450, 1'b1, 1'b0, 1'b1, 5'd1, 4, 12, 3};

    bus.req_valid = 1'b0; bus.req_addr = '0;
    done = 1'b0; found_in_cache = 1'b0; way_index = '0;
    replace = 1'b0; updated = 1'b0; mem_valid = 1'b0; mem_block = '0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("reset req_ready", bus.req_ready, 1'b1);
    chk("reset commands", {find_start, update_start, block_replace, mem_req, bus.resp_valid, bus.resp_hit}, 6'b0);
    chk("reset replace_way", replace_way, 5'd0);
    chk("reset counters", {hit_count, miss_count, replace_count}, 48'd0);
    chk("reset block", block, 128'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset fields", {tag, index, block_offset}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      do_access(vecs[i].addr, vecs[i].hold, g_hit, g_repl, g_rway);
      chk($sformatf("vec%0d hit", i), g_hit, vecs[i].hit);
      chk($sformatf("vec%0d repl", i), g_repl, vecs[i].repl);
      if (vecs[i].repl) chk($sformatf("vec%0d rway", i), g_rway, vecs[i].rway);
      chk($sformatf("vec%0d counts", i), {hit_count, miss_count, replace_count},
          {16'(vecs[i].hits), 16'(vecs[i].misses), 16'(vecs[i].repls)});
    end

    // Reset while waiting for memory: request abandoned, no response.
    bus.req_valid = 1'b1; bus.req_addr = 32'h0000_5670;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    done = 1'b1; found_in_cache = 1'b0;
    @(negedge clk);
    done = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin @(negedge clk); n++; end
    chk("mid-MEM mem_req", mem_req, 1'b1);
    rs0 = resp_pulses;
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset drops mem_req", mem_req, 1'b0);
    chk("reset clears counters", {hit_count, miss_count, replace_count}, 48'd0);
    chk("reset back to idle", bus.req_ready, 1'b1);
    rst_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    chk("no response after reset", 32'(resp_pulses - rs0), 32'd0);

    // Cold miss again: LRU ages restart with way 3 as first victim.
    do_access(32'h0000_1230, 1'b0, g_hit, g_repl, g_rway);
    chk("post-reset cold miss", g_hit, 1'b0);

    for (int t = 0; t < 250; t++) begin
      logic [31:0] a;
      int sel, ix;
      sel = int'($urandom_range(0, 3));
      ix = (sel == 0) ? 32'h023 : (sel == 1) ? 32'h045 : (sel == 2) ? 32'h123 : int'($urandom_range(0, 511));
      a = (32'($urandom_range(0, 7)) << 13) | (32'(ix) << 4) | 32'($urandom_range(0, 15));
      do_access(a, 1'($urandom_range(0, 1)), g_hit, g_repl, g_rway);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_access_ctrl.md
CACHE_ACCESS_CTRL -- requirements
Module: cache_access_ctrl

Interface
REQ-001 Parameter WAY, default 4, cache associativity (power of two, 2..16).
REQ-002 Parameter BLOCK_SIZE_BYTE, default 16, line size in bytes.
REQ-003 Parameter CACHE_SIZE_BYTE, default 32768, total capacity; SET = CACHE_SIZE_BYTE/(BLOCK_SIZE_BYTE*WAY), SET_INDEX = log2(SET), OFFSET = log2(BLOCK_SIZE_BYTE).
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid / req_ready  input / output  1 / 1  CPU request handshake; transfer when both high on a clk edge.
REQ-007 req_addr  input  32  byte address: tag = [31:SET_INDEX+OFFSET], index = [SET_INDEX+OFFSET-1:OFFSET], block_offset = [OFFSET-1:0].
REQ-008 tag, index, block_offset  output  32-SET_INDEX-OFFSET, SET_INDEX, OFFSET  latched request fields driven to the cache.
REQ-009 find_start, update_start  output  1 each  single-cycle lookup / fill commands to the cache.
REQ-010 found_in_cache, done  input  1 each  lookup result; done is a one-cycle pulse, found_in_cache is valid with it.
REQ-011 way_index  input  5  cache way pointer; on done with hit, and on updated without a preceding replace, the accessed way is way_index-1.
REQ-012 replace, updated  input  1 each  cache reports no free way / fill complete.
REQ-013 block_replace  output  1  forces the cache to write the victim way.
REQ-014 replace_way  output  5  victim way, valid while block_replace is high.
REQ-015 block  output  BLOCK_SIZE_BYTE*8  refill line driven to the cache.
REQ-016 mem_req / mem_addr  output  1 / 32  line fetch request; mem_addr is req_addr with offset bits zeroed.
REQ-017 mem_valid / mem_block  input  1 / BLOCK_SIZE_BYTE*8  refill return, one-cycle pulse.
REQ-018 resp_valid / resp_hit  output  1 / 1  one-cycle completion pulse; resp_hit=1 for a hit.
REQ-019 hit_count, miss_count, replace_count  output  16 each  statistics.

Function
REQ-020 FSM states: IDLE, FIND, WAIT_FIND, MEM, FILL, WAIT_FILL, REPLACE, RESP.
REQ-021 IDLE: req_ready=1; on handshake, latch tag/index/block_offset and go to FIND.
REQ-022 FIND: find_start=1 for exactly one cycle, then WAIT_FIND.
REQ-023 WAIT_FIND: on done & found_in_cache, record hit way, update LRU, hit_count+1, go to RESP with resp_hit=1; on done & !found_in_cache, miss_count+1, go to MEM.
REQ-024 MEM: mem_req held high until mem_valid; on mem_valid latch mem_block into block, deassert mem_req, go to FILL.
REQ-025 FILL: update_start=1 for exactly one cycle, then WAIT_FILL.
REQ-026 WAIT_FILL: on updated (without replace), fill way = way_index-1, update LRU, go to RESP (resp_hit=0); on replace, go to REPLACE.
REQ-027 REPLACE: replace_way = LRU victim of index, block_replace=1 held until updated; on updated, drop block_replace, update LRU for replace_way, replace_count+1, go to RESP.
REQ-028 RESP: resp_valid=1 for one cycle, then IDLE; req_ready=0 in every state except IDLE.
REQ-029 LRU: per set, per way, a log2(WAY)-bit age; an access to way w sets age[w]=0 and increments every age strictly less than the old age[w]; other ages unchanged.
REQ-030 Victim = the way with age WAY-1; ages per set always form a permutation of 0..WAY-1.
REQ-031 Counters wrap from 16'hFFFF to 0 without saturation.
REQ-032 req_valid outside IDLE is ignored (not latched); mem_valid outside MEM is ignored.
REQ-033 A done arriving in the same cycle as find_start is not possible; a done outside WAIT_FIND is ignored.
REQ-034 block remains stable from FILL until RESP.

Reset
REQ-035 rst_n=0 at a clk edge: state=IDLE, all command outputs (find_start, update_start, block_replace, mem_req, resp_valid, resp_hit) = 0, replace_way=0, counters=0, block=0, mem_addr=0, tag/index/block_offset=0.
REQ-036 Reset initialises every set's ages to age[w]=w (way WAY-1 is the first victim).
REQ-037 Reset mid-operation aborts the transaction with no response and no counter update; the cache is reset independently.

Verification
REQ-038 Cold miss: addr 0x0000_1230 -> find_start, done/!found, mem_req with mem_addr 0x0000_1230, fill of way 0, resp_valid with resp_hit=0, miss_count=1.
REQ-039 Same address again -> done/found, resp_hit=1, no mem_req, hit_count=1, way 0 age 0.
REQ-040 Five distinct tags to index 0x023 with WAY=4 -> 4 fills into ways 0..3, 5th gets replace, block_replace with replace_way=0, replace_count=1.
REQ-041 Hit way 0 before the 5th miss -> replace_way=1.
REQ-042 req_valid held high during a miss -> only one request accepted; rst_n low mid-MEM -> mem_req=0 next cycle, no resp_valid.
REQ-043 65536 hits -> hit_count returns to 0.
